// File: rtl/sprite_renderer_pkg.sv
// Shared constants, state encoding and width helper for the sprite renderer.
// Pure declarations; no logic, no latency.
package sprite_renderer_pkg;

   localparam int DEF_RES_H  = 640;
   localparam int DEF_SPR_W  = 16;
   localparam int DEF_SPR_H  = 8;
   localparam int DEF_SCALE  = 2;
   localparam int DEF_FRAMES = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_AWAIT_POS = 3'd2,
      ST_DRAW      = 3'd3,
      ST_NEXT_LINE = 3'd4
   } state_t;

   // Counter/select width for a limit, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_renderer_if.sv
// Control, bitmap write and pixel output bundle of the sprite renderer.
// master drives controls and writes; slave is the renderer.
interface sprite_renderer_if
   import sprite_renderer_pkg::*;
#(
   parameter int SPR_W  = DEF_SPR_W,
   parameter int SPR_H  = DEF_SPR_H,
   parameter int FRAMES = DEF_FRAMES,
   parameter int RES_H  = DEF_RES_H
);
   localparam int FRAME_W = clog2_min1(FRAMES);
   localparam int ROW_W   = clog2_min1(SPR_H);
   localparam int PIX_W   = clog2_min1(RES_H);

   logic               start;
   logic [FRAME_W-1:0] frame;
   logic               hflip;
   logic               abort;
   logic [9:0]         spr_x;
   logic [PIX_W-1:0]   pixel_x;
   logic               wr_en;
   logic [FRAME_W-1:0] wr_frame;
   logic [ROW_W-1:0]   wr_row;
   logic [SPR_W-1:0]   wr_data;
   logic               spr_draw;
   logic               busy;
   logic               done;

   modport master (
      output start, frame, hflip, abort, spr_x, pixel_x,
      output wr_en, wr_frame, wr_row, wr_data,
      input  spr_draw, busy, done
   );

   modport slave (
      input  start, frame, hflip, abort, spr_x, pixel_x,
      input  wr_en, wr_frame, wr_row, wr_data,
      output spr_draw, busy, done
   );

endinterface

// File: rtl/sprite_bitmap_ram.sv
// Sprite bitmap store: FRAMES*SPR_H rows of SPR_W bits, sync write, async read.
// Writes land at the clock edge and are visible to the read port the next cycle.
module sprite_bitmap_ram
   import sprite_renderer_pkg::*;
#(
   parameter int SPR_W  = DEF_SPR_W,
   parameter int SPR_H  = DEF_SPR_H,
   parameter int FRAMES = DEF_FRAMES
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               wr_en,
   input  logic [clog2_min1(FRAMES)-1:0]      wr_frame,
   input  logic [clog2_min1(SPR_H)-1:0]       wr_row,
   input  logic [SPR_W-1:0]                   wr_data,
   input  logic [clog2_min1(FRAMES)-1:0]      rd_frame,
   input  logic [clog2_min1(SPR_H)-1:0]       rd_row,
   output logic [SPR_W-1:0]                   rd_data
);
   logic [SPR_W-1:0] mem [FRAMES][SPR_H];
   logic             wr_ok;
   logic             rd_ok;

   // Contents survive reset; reset only blocks a write issued in the same cycle.
   assign wr_ok = wr_en && !rst && (int'(wr_frame) < FRAMES) && (int'(wr_row) < SPR_H);
   assign rd_ok = (int'(rd_frame) < FRAMES) && (int'(rd_row) < SPR_H);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_frame][wr_row] <= wr_data;
      end
   end

   assign rd_data = rd_ok ? mem[rd_frame][rd_row] : '0;

endmodule

// File: rtl/sprite_renderer.sv
// Scaled, mirrored, multi-frame sprite scanout keyed to the beam column.
// spr_draw is combinational from state and bitmap; done is a registered 1-cycle pulse.
module sprite_renderer
   import sprite_renderer_pkg::*;
#(
   parameter int SPR_W  = DEF_SPR_W,
   parameter int SPR_H  = DEF_SPR_H,
   parameter int SCALE  = DEF_SCALE,
   parameter int FRAMES = DEF_FRAMES,
   parameter int RES_H  = DEF_RES_H
) (
   input  logic              clk,
   input  logic              rst,
   sprite_renderer_if.slave  bus
);
   localparam int FRAME_W = clog2_min1(FRAMES);
   localparam int ROW_W   = clog2_min1(SPR_H);
   localparam int COL_W   = clog2_min1(SPR_W);
   localparam int CNT_W   = clog2_min1(SCALE);

   localparam logic [COL_W-1:0] X_LAST = COL_W'(SPR_W - 1);
   localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(SPR_H - 1);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SCALE - 1);

   state_t             state, state_nxt;
   logic [COL_W-1:0]   x, x_nxt;
   logic [ROW_W-1:0]   y, y_nxt;
   logic [CNT_W-1:0]   cx, cx_nxt;
   logic [CNT_W-1:0]   cy, cy_nxt;
   logic [FRAME_W-1:0] frame_q;
   logic               hflip_q;
   logic               done, done_nxt;
   logic               start_ok;
   logic               at_pos;
   logic               last_line;
   logic [COL_W-1:0]   col;
   logic [SPR_W-1:0]   row_dat;

   assign start_ok  = bus.start && (int'(bus.spr_x) < RES_H);
   assign at_pos    = (int'(bus.pixel_x) == int'(bus.spr_x));
   assign last_line = (y == Y_LAST) && (cy == C_LAST);

   always_comb begin
      state_nxt = state;
      x_nxt     = x;
      y_nxt     = y;
      cx_nxt    = cx;
      cy_nxt    = cy;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_nxt = ST_START;
         end
         ST_START: begin
            y_nxt     = '0;
            cy_nxt    = '0;
            state_nxt = ST_AWAIT_POS;
         end
         ST_AWAIT_POS: begin
            x_nxt  = '0;
            cx_nxt = '0;
            if (at_pos) state_nxt = ST_DRAW;
         end
         ST_DRAW: begin
            if (cx == C_LAST) begin
               cx_nxt = '0;
               if (x == X_LAST) begin
                  if (last_line) begin
                     state_nxt = ST_IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_NEXT_LINE;
                  end
               end else begin
                  x_nxt = x + 1'b1;
               end
            end else begin
               cx_nxt = cx + 1'b1;
            end
         end
         ST_NEXT_LINE: begin
            if (cy == C_LAST) begin
               cy_nxt = '0;
               y_nxt  = y + 1'b1;
            end else begin
               cy_nxt = cy + 1'b1;
            end
            state_nxt = ST_AWAIT_POS;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // Abort wins over every transition, including a start seen in IDLE.
      if (bus.abort) begin
         state_nxt = ST_IDLE;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         x       <= '0;
         y       <= '0;
         cx      <= '0;
         cy      <= '0;
         frame_q <= '0;
         hflip_q <= 1'b0;
         done    <= 1'b0;
      end else begin
         state <= state_nxt;
         x     <= x_nxt;
         y     <= y_nxt;
         cx    <= cx_nxt;
         cy    <= cy_nxt;
         done  <= done_nxt;
         if (state == ST_IDLE && start_ok && !bus.abort) begin
            frame_q <= bus.frame;
            hflip_q <= bus.hflip;
         end
      end
   end

   sprite_bitmap_ram #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .FRAMES (FRAMES)
   ) u_ram (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bus.wr_en),
      .wr_frame (bus.wr_frame),
      .wr_row   (bus.wr_row),
      .wr_data  (bus.wr_data),
      .rd_frame (frame_q),
      .rd_row   (y),
      .rd_data  (row_dat)
   );

   // Bit SPR_W-1 is the leftmost source pixel unless mirrored.
   assign col          = hflip_q ? x : (X_LAST - x);
   assign bus.spr_draw = (state == ST_DRAW) && row_dat[col];
   assign bus.busy     = (state != ST_IDLE);
   assign bus.done     = done;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench: stimulus queues per-cycle expected {spr_draw,busy,done}; a negedge monitor compares.
// Two DUTs: default parameters, and SPR_W=8/SPR_H=4/SCALE=1.
module tb_sprite_renderer;
   import sprite_renderer_pkg::*;

   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   sprite_renderer_if i0 ();
   sprite_renderer_if #(.SPR_W(8), .SPR_H(4)) i1 ();

   sprite_renderer u_dut0 (.clk(clk), .rst(rst0), .bus(i0));
   sprite_renderer #(.SPR_W(8), .SPR_H(4), .SCALE(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(i1));

   typedef struct {
      int    cyc;
      logic  drw;
      logic  bsy;
      logic  dn;
      string nm;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   int          draw_cnt0 = 0;
   int          draw_cnt1 = 0;
   int          done_cnt0 = 0;
   logic [15:0] bm [2][2][8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_out(input int d, input int c, input logic dr, input logic b,
                             input logic dn, input string nm);
      exp_t e;
      e.cyc = c; e.drw = dr; e.bsy = b; e.dn = dn; e.nm = nm;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int d);
      exp_t       e;
      logic [2:0] act;
      int         sz;
      act = (d == 0) ? {i0.spr_draw, i0.busy, i0.done} : {i1.spr_draw, i1.busy, i1.done};
      while (1) begin
         sz = (d == 0) ? q0.size() : q1.size();
         if (sz == 0) break;
         e = (d == 0) ? q0[0] : q1[0];
         if (e.cyc > cyc) break;
         if (d == 0) e = q0.pop_front();
         else        e = q1.pop_front();
         n_cmp++;
         if (e.cyc != cyc || act !== {e.drw, e.bsy, e.dn}) begin
            n_err++;
            $display("FAIL %s dut%0d cycle %0d (due %0d): draw/busy/done got %b required %b",
                     e.nm, d, cyc, e.cyc, act, {e.drw, e.bsy, e.dn});
         end
      end
   endtask

   always @(negedge clk) begin
      if (i0.spr_draw === 1'b1) draw_cnt0++;
      if (i1.spr_draw === 1'b1) draw_cnt1++;
      if (i0.done === 1'b1)     done_cnt0++;
      mon(0);
      mon(1);
   end

   task automatic check_val(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic wr(input int d, input int f, input int r, input logic [15:0] v);
      if (d == 0) begin
         i0.wr_en = 1'b1; i0.wr_frame = f[0]; i0.wr_row = r[2:0]; i0.wr_data = v;
         bm[0][f][r] = v;
      end else begin
         i1.wr_en = 1'b1; i1.wr_frame = f[0]; i1.wr_row = r[1:0]; i1.wr_data = v[7:0];
         bm[1][f][r] = {8'h00, v[7:0]};
      end
      step();
      i0.wr_en = 1'b0;
      i1.wr_en = 1'b0;
   endtask

   task automatic go(input int d, input int f, input logic hf);
      if (d == 0) begin i0.start = 1'b1; i0.frame = f[0]; i0.hflip = hf; end
      else        begin i1.start = 1'b1; i1.frame = f[0]; i1.hflip = hf; end
      step();
      i0.start = 1'b0;
      i1.start = 1'b0;
   endtask

   // Expected outputs for an uninterrupted sprite whose START state is cycle c0
   // (pixel_x parked on spr_x, so each AWAIT_POS lasts one cycle).
   task automatic push_sprite(input int d, input int c0, input int w, input int h, input int s,
                              input int f, input logic hf, output int cdone);
      int c;
      int col;
      int b;
      c = c0;
      expect_out(d, c, 1'b0, 1'b1, 1'b0, "start_state"); c++;
      for (int ln = 0; ln < h * s; ln++) begin
         expect_out(d, c, 1'b0, 1'b1, 1'b0, "await_pos"); c++;
         for (int k = 0; k < w * s; k++) begin
            col = k / s;
            b   = hf ? col : (w - 1 - col);
            expect_out(d, c, bm[d][f][ln / s][b], 1'b1, 1'b0, "draw_px"); c++;
         end
         if (ln != h * s - 1) begin
            expect_out(d, c, 1'b0, 1'b1, 1'b0, "next_line"); c++;
         end
      end
      expect_out(d, c, 1'b0, 1'b0, 1'b1, "done_pulse");
      cdone = c;
      expect_out(d, c + 1, 1'b0, 1'b0, 1'b0, "idle_after");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, cd, d0, k0;
      rst0 = 1'b1; rst1 = 1'b1;
      i0.start = 0; i0.frame = 0; i0.hflip = 0; i0.abort = 0; i0.spr_x = 0; i0.pixel_x = 0;
      i0.wr_en = 0; i0.wr_frame = 0; i0.wr_row = 0; i0.wr_data = 0;
      i1.start = 0; i1.frame = 0; i1.hflip = 0; i1.abort = 0; i1.spr_x = 0; i1.pixel_x = 0;
      i1.wr_en = 0; i1.wr_frame = 0; i1.wr_row = 0; i1.wr_data = 0;
      repeat (3) step();
      expect_out(0, cyc, 1'b0, 1'b0, 1'b0, "reset_state");
      expect_out(1, cyc, 1'b0, 1'b0, 1'b0, "reset_state");
      rst0 = 1'b0; rst1 = 1'b0;
      step();
      i0.spr_x = 10'd100; i0.pixel_x = 10'd100;
      i1.spr_x = 10'd5;   i1.pixel_x = 10'd5;

      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 8; r++) wr(0, f, r, 16'h0000);

      // Row 0 = 8001: lit on DRAW cycles 0-1 and 30-31 of its two lines.
      wr(0, 0, 0, 16'h8001);
      c0 = cyc + 1; d0 = draw_cnt0; k0 = done_cnt0;
      push_sprite(0, c0, 16, 8, 2, 0, 1'b0, cd);
      go(0, 0, 1'b0);
      wait_until(cd + 2);
      check_val("t1_draw_cycles", draw_cnt0 - d0, 8);
      check_val("t1_done_pulses", done_cnt0 - k0, 1);

      // Mirrored 8000: only the last two DRAW cycles of each row-0 line.
      wr(0, 0, 0, 16'h8000);
      c0 = cyc + 1; d0 = draw_cnt0;
      push_sprite(0, c0, 16, 8, 2, 0, 1'b1, cd);
      go(0, 0, 1'b1);
      wait_until(cd + 2);
      check_val("t2_draw_cycles", draw_cnt0 - d0, 4);

      // All ones: 16*8*2*2 lit cycles.
      for (int r = 0; r < 8; r++) wr(0, 0, r, 16'hFFFF);
      c0 = cyc + 1; d0 = draw_cnt0; k0 = done_cnt0;
      push_sprite(0, c0, 16, 8, 2, 0, 1'b0, cd);
      go(0, 0, 1'b0);
      wait_until(cd + 2);
      check_val("t3_draw_cycles", draw_cnt0 - d0, 512);
      check_val("t3_done_pulses", done_cnt0 - k0, 1);

      // Abort in the third DRAW cycle, then a fresh full draw.
      c0 = cyc + 1; k0 = done_cnt0;
      expect_out(0, c0,     1'b0, 1'b1, 1'b0, "t4_start");
      expect_out(0, c0 + 1, 1'b0, 1'b1, 1'b0, "t4_await");
      expect_out(0, c0 + 2, 1'b1, 1'b1, 1'b0, "t4_draw0");
      expect_out(0, c0 + 3, 1'b1, 1'b1, 1'b0, "t4_draw1");
      expect_out(0, c0 + 4, 1'b1, 1'b1, 1'b0, "t4_draw2");
      expect_out(0, c0 + 5, 1'b0, 1'b0, 1'b0, "t4_aborted");
      expect_out(0, c0 + 6, 1'b0, 1'b0, 1'b0, "t4_idle");
      go(0, 0, 1'b0);
      wait_until(c0 + 4);
      i0.abort = 1'b1;
      step();
      i0.abort = 1'b0;
      wait_until(c0 + 8);
      check_val("t4_no_done", done_cnt0 - k0, 0);
      c0 = cyc + 1; d0 = draw_cnt0; k0 = done_cnt0;
      push_sprite(0, c0, 16, 8, 2, 0, 1'b0, cd);
      go(0, 0, 1'b0);
      wait_until(cd + 2);
      check_val("t4_redraw_cycles", draw_cnt0 - d0, 512);
      check_val("t4_redraw_done", done_cnt0 - k0, 1);

      // Start while busy (frame 1, mirrored) must not disturb the frame-0 draw.
      for (int r = 0; r < 8; r++) wr(0, 0, r, 16'h00FF);
      c0 = cyc + 1; d0 = draw_cnt0;
      push_sprite(0, c0, 16, 8, 2, 0, 1'b0, cd);
      go(0, 0, 1'b0);
      wait_until(c0 + 50);
      i0.frame = 1'b1; i0.hflip = 1'b1; i0.start = 1'b1;
      step();
      i0.start = 1'b0; i0.frame = 1'b0; i0.hflip = 1'b0;
      wait_until(cd + 2);
      check_val("t5_draw_cycles", draw_cnt0 - d0, 256);

      // Start with spr_x off-screen is ignored.
      i0.spr_x = 10'd700; i0.pixel_x = 10'd700;
      c0 = cyc + 1;
      expect_out(0, c0,     1'b0, 1'b0, 1'b0, "t5_offscreen0");
      expect_out(0, c0 + 1, 1'b0, 1'b0, 1'b0, "t5_offscreen1");
      expect_out(0, c0 + 2, 1'b0, 1'b0, 1'b0, "t5_offscreen2");
      go(0, 0, 1'b0);
      wait_until(c0 + 3);
      i0.spr_x = 10'd100;

      // Beam away from spr_x holds AWAIT_POS; a row write lands mid-draw.
      i0.pixel_x = 10'd0;
      c0 = cyc + 1;
      expect_out(0, c0, 1'b0, 1'b1, 1'b0, "t6_start");
      for (int i = 1; i <= 5; i++) expect_out(0, c0 + i, 1'b0, 1'b1, 1'b0, "t6_await");
      expect_out(0, c0 + 6, 1'b1, 1'b1, 1'b0, "t6_draw_mirror");
      expect_out(0, c0 + 7, 1'b0, 1'b1, 1'b0, "t6_live_write");
      expect_out(0, c0 + 8, 1'b0, 1'b0, 1'b0, "t6_abort");
      go(0, 0, 1'b1);
      wait_until(c0 + 5);
      i0.pixel_x = 10'd100;
      step();
      wr(0, 0, 0, 16'h0000);
      i0.abort = 1'b1;
      step();
      i0.abort = 1'b0;
      wait_until(c0 + 10);

      // Small unscaled sprite: reset mid-row, then the bitmap must still be intact.
      wr(1, 0, 0, 16'h00A5);
      wr(1, 0, 1, 16'h003C);
      wr(1, 0, 2, 16'h0081);
      wr(1, 0, 3, 16'h00FF);
      c0 = cyc + 1;
      expect_out(1, c0,     1'b0, 1'b1, 1'b0, "t7_start");
      expect_out(1, c0 + 1, 1'b0, 1'b1, 1'b0, "t7_await");
      expect_out(1, c0 + 2, 1'b1, 1'b1, 1'b0, "t7_px0");
      expect_out(1, c0 + 3, 1'b0, 1'b1, 1'b0, "t7_px1");
      expect_out(1, c0 + 4, 1'b1, 1'b1, 1'b0, "t7_px2");
      expect_out(1, c0 + 5, 1'b0, 1'b1, 1'b0, "t7_px3");
      expect_out(1, c0 + 6, 1'b0, 1'b0, 1'b0, "t7_after_rst");
      expect_out(1, c0 + 7, 1'b0, 1'b0, 1'b0, "t7_idle");
      go(1, 0, 1'b0);
      wait_until(c0 + 5);
      rst1 = 1'b1;
      step();
      rst1 = 1'b0;
      wait_until(c0 + 8);
      c0 = cyc + 1; d0 = draw_cnt1;
      push_sprite(1, c0, 8, 4, 1, 0, 1'b0, cd);
      go(1, 0, 1'b0);
      wait_until(cd + 2);
      check_val("t7_draw_cycles", draw_cnt1 - d0, 18);

      for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) step();
      check_val("queue0_drained", q0.size(), 0);
      check_val("queue1_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
